// File: rtl/adder_pkg.sv
// Shared constants and the in-flight tag type for the four-operand adder and its arbiter.
package adder_pkg;

  localparam int OP_W        = 13;
  localparam int SUM_W       = 15;
  localparam int OPS_PER_REQ = 4;
  localparam int REQ_OPS_W   = OP_W * OPS_PER_REQ;
  localparam int CNT_W       = 16;
  // Wide enough for the largest supported requester count (8).
  localparam int ID_MAX_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and result bus between compute clients and the shared adder arbiter.
interface adder_arbiter_if
  import adder_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  // Requester i hands off an operation in a cycle where req_valid[i] and req_ready[i]
  // are both high; req_valid/req_ops must hold until then. Results have no back-pressure:
  // res_id/res_data must be taken in the cycle res_valid is high.
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*REQ_OPS_W-1:0] req_ops;
  logic [N_REQ-1:0]           req_ready;
  logic                       res_valid;
  logic [ID_W-1:0]            res_id;
  logic [SUM_W-1:0]           res_data;

  modport master (
    output req_valid, req_ops,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_ops,
    output req_ready, res_valid, res_id, res_data
  );

endinterface

// File: rtl/adder_arbiter_adder4.sv
// Two-stage pipelined four-operand unsigned adder: pair sums, then the final sum.
module adder_arbiter_adder4
  import adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op1,
  input  logic [OP_W-1:0]  op2,
  input  logic [OP_W-1:0]  op3,
  input  logic [OP_W-1:0]  op4,
  output logic [SUM_W-1:0] sum
);

  logic [OP_W:0]    s01_d, s01_q;
  logic [OP_W:0]    s23_d, s23_q;
  logic [SUM_W-1:0] sum_d, sum_q;

  always_comb begin
    s01_d = {1'b0, op1} + {1'b0, op2};
    s23_d = {1'b0, op3} + {1'b0, op4};
    sum_d = {1'b0, s01_q} + {1'b0, s23_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s01_q <= '0;
      s23_q <= '0;
      sum_q <= '0;
    end else begin
      s01_q <= s01_d;
      s23_q <= s23_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one pipelined four-operand adder between N_REQ requesters;
// a two-stage tag pipeline labels each result with its requester ID.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  adder_arbiter_if.slave    bus,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt,
  output logic [ID_W-1:0]   ptr_dbg
);

  logic [ID_W-1:0]      ptr_d, ptr_q;
  tag_t                 tag0_d, tag0_q;
  tag_t                 tag1_d, tag1_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;

  logic                 grant;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      cand;
  logic [REQ_OPS_W-1:0] ops_sel;

  // Search from ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (en && !grant && bus.req_valid[cand]) begin
        grant    = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    ops_sel = '0;
    ptr_d   = ptr_q;
    if (grant) begin
      ops_sel = bus.req_ops[int'(grant_id)*REQ_OPS_W +: REQ_OPS_W];
      ptr_d   = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    end
    tag0_d = '{valid: grant, id: ID_MAX_W'(grant_id)};
    tag1_d = tag0_q;
    cnt_d  = cnt_q;
    if (tag1_q.valid && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      tag0_q <= '0;
      tag1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      tag0_q <= tag0_d;
      tag1_q <= tag1_d;
      cnt_q  <= cnt_d;
    end
  end

  adder_arbiter_adder4 u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .op1   (ops_sel[OP_W-1:0]),
    .op2   (ops_sel[2*OP_W-1:OP_W]),
    .op3   (ops_sel[3*OP_W-1:2*OP_W]),
    .op4   (ops_sel[4*OP_W-1:3*OP_W]),
    .sum   (bus.res_data)
  );

  assign bus.req_ready = grant ? (N_REQ'(1) << grant_id) : '0;
  assign bus.res_valid = tag1_q.valid;
  assign bus.res_id    = tag1_q.id[ID_W-1:0];
  assign busy          = tag0_q.valid | tag1_q.valid;
  assign done_cnt      = cnt_q;
  assign ptr_dbg       = ptr_q;

endmodule
